// File: rtl/ball_mover.sv
// ball_mover: tilt-driven ball position engine with map-ROM wall checks; optional hit counter under BALL_HIT_CNT_EN.
// Phase accumulators raise per-axis pending steps; the FSM checks bounds locally and then queries the map ROM.
module ball_mover #(
  parameter int unsigned POS_WIDTH = 8,
  parameter int unsigned MAG_WIDTH = 8,
  parameter int unsigned ACC_WIDTH = 20,
  parameter int unsigned X_MAX     = 159,
  parameter int unsigned Y_MAX     = 119,
  parameter int unsigned X_INIT    = 0,
  parameter int unsigned Y_INIT    = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 x_increment,
  input  logic                 x_decrement,
  input  logic                 y_increment,
  input  logic                 y_decrement,
  input  logic [MAG_WIDTH-1:0] x_threshold,
  input  logic [MAG_WIDTH-1:0] y_threshold,
  output logic                 map_req,
  output logic [POS_WIDTH-1:0] map_x,
  output logic [POS_WIDTH-1:0] map_y,
  input  logic                 map_ack,
  input  logic                 map_blocked,
  output logic [POS_WIDTH-1:0] x_out,
  output logic [POS_WIDTH-1:0] y_out,
  output logic                 hit,
  output logic                 busy,
  output logic [15:0]          hit_count
);

  typedef enum logic [1:0] {IDLE, QUERY_X, QUERY_Y} state_t;

  localparam int unsigned SUM_W = ((ACC_WIDTH > MAG_WIDTH) ? ACC_WIDTH : MAG_WIDTH) + 1;
  localparam logic [POS_WIDTH-1:0] X_LIM = POS_WIDTH'(X_MAX);
  localparam logic [POS_WIDTH-1:0] Y_LIM = POS_WIDTH'(Y_MAX);

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic                   pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic                   dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic                   rr_q, rr_d;
  logic [POS_WIDTH-1:0]   x_q, x_d, y_q, y_d;
  logic [POS_WIDTH-1:0]   mx_q, mx_d, my_q, my_d;
  logic                   hit_q, hit_d;

  logic                   x_act, y_act, carry_x, carry_y, clr_x, clr_y;
  logic                   sel_x, sel_y, x_oob, y_oob;
  logic [SUM_W-1:0]       sum_x, sum_y;
  logic [POS_WIDTH-1:0]   cand_x, cand_y;

  // {inc,dec} of 10 or 01 is active; 00 and 11 park the accumulator at zero.
  assign x_act = x_increment ^ x_decrement;
  assign y_act = y_increment ^ y_decrement;
  assign sum_x = {{(SUM_W-ACC_WIDTH){1'b0}}, acc_x_q} + {{(SUM_W-MAG_WIDTH){1'b0}}, x_threshold};
  assign sum_y = {{(SUM_W-ACC_WIDTH){1'b0}}, acc_y_q} + {{(SUM_W-MAG_WIDTH){1'b0}}, y_threshold};
  assign carry_x = x_act & (|sum_x[SUM_W-1:ACC_WIDTH]);
  assign carry_y = y_act & (|sum_y[SUM_W-1:ACC_WIDTH]);
  assign acc_x_d = x_act ? sum_x[ACC_WIDTH-1:0] : '0;
  assign acc_y_d = y_act ? sum_y[ACC_WIDTH-1:0] : '0;

  assign cand_x = dir_x_q ? x_q + 1'b1 : x_q - 1'b1;
  assign cand_y = dir_y_q ? y_q + 1'b1 : y_q - 1'b1;
  assign x_oob  = dir_x_q ? (x_q == X_LIM) : (x_q == '0);
  assign y_oob  = dir_y_q ? (y_q == Y_LIM) : (y_q == '0);

  // rr_q=1 means Y gets first look after an X step was serviced.
  assign sel_y = pend_y_q & (rr_q | ~pend_x_q);
  assign sel_x = pend_x_q & ~sel_y;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    mx_d    = mx_q;
    my_d    = my_q;
    rr_d    = rr_q;
    hit_d   = 1'b0;
    clr_x   = 1'b0;
    clr_y   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_x) begin
          rr_d = 1'b1;
          if (x_oob) begin
            hit_d = 1'b1;
            clr_x = 1'b1;
          end else begin
            state_d = QUERY_X;
            mx_d    = cand_x;
            my_d    = y_q;
          end
        end else if (sel_y) begin
          rr_d = 1'b0;
          if (y_oob) begin
            hit_d = 1'b1;
            clr_y = 1'b1;
          end else begin
            state_d = QUERY_Y;
            mx_d    = x_q;
            my_d    = cand_y;
          end
        end
      end
      QUERY_X: begin
        if (map_ack) begin
          if (map_blocked) hit_d = 1'b1;
          else             x_d   = mx_q;
          clr_x   = 1'b1;
          state_d = IDLE;
        end
      end
      QUERY_Y: begin
        if (map_ack) begin
          if (map_blocked) hit_d = 1'b1;
          else             y_d   = my_q;
          clr_y   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A carry arriving while the flag is set (even on its clearing cycle) is dropped.
  assign pend_x_d = clr_x ? 1'b0 : (pend_x_q | carry_x);
  assign pend_y_d = clr_y ? 1'b0 : (pend_y_q | carry_y);
  assign dir_x_d  = (!pend_x_q && carry_x) ? x_increment : dir_x_q;
  assign dir_y_d  = (!pend_y_q && carry_y) ? y_increment : dir_y_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      acc_x_q  <= '0;
      acc_y_q  <= '0;
      pend_x_q <= 1'b0;
      pend_y_q <= 1'b0;
      dir_x_q  <= 1'b0;
      dir_y_q  <= 1'b0;
      rr_q     <= 1'b0;
      x_q      <= POS_WIDTH'(X_INIT);
      y_q      <= POS_WIDTH'(Y_INIT);
      mx_q     <= '0;
      my_q     <= '0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_x_q  <= acc_x_d;
      acc_y_q  <= acc_y_d;
      pend_x_q <= pend_x_d;
      pend_y_q <= pend_y_d;
      dir_x_q  <= dir_x_d;
      dir_y_q  <= dir_y_d;
      rr_q     <= rr_d;
      x_q      <= x_d;
      y_q      <= y_d;
      mx_q     <= mx_d;
      my_q     <= my_d;
      hit_q    <= hit_d;
    end
  end

`ifdef BALL_HIT_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  assign cnt_d = (hit_d && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
  assign hit_count = cnt_q;
`else
  assign hit_count = 16'h0000;
`endif

  assign map_req = (state_q != IDLE);
  assign busy    = (state_q != IDLE);
  assign map_x   = mx_q;
  assign map_y   = my_q;
  assign x_out   = x_q;
  assign y_out   = y_q;
  assign hit     = hit_q;

endmodule

// File: tb/tb_ball_mover.sv
// Directed bench for ball_mover: ACC_WIDTH=4, start (5,5), Y_MAX shrunk to 9 to reach the edge quickly.
module tb_ball_mover;

  logic       clk = 1'b0;
  logic       reset;
  logic       x_increment, x_decrement, y_increment, y_decrement;
  logic [7:0] x_threshold, y_threshold;
  logic       map_req, map_ack, map_blocked, hit, busy;
  logic [7:0] map_x, map_y, x_out, y_out;
  logic [15:0] hit_count;

  logic tie_ack, man_ack, blk_en;
  int   n_vec = 0;
  int   n_err = 0;

`ifdef BALL_HIT_CNT_EN
  localparam int HC_EN = 1;
`else
  localparam int HC_EN = 0;
`endif

  assign map_ack     = tie_ack ? map_req : man_ack;
  assign map_blocked = blk_en && (map_x == 8'd7);

  always #5 clk = ~clk;

  ball_mover #(
    .POS_WIDTH(8), .MAG_WIDTH(8), .ACC_WIDTH(4),
    .X_MAX(159), .Y_MAX(9), .X_INIT(5), .Y_INIT(5)
  ) dut (
    .clk(clk), .reset(reset),
    .x_increment(x_increment), .x_decrement(x_decrement),
    .y_increment(y_increment), .y_decrement(y_decrement),
    .x_threshold(x_threshold), .y_threshold(y_threshold),
    .map_req(map_req), .map_x(map_x), .map_y(map_y),
    .map_ack(map_ack), .map_blocked(map_blocked),
    .x_out(x_out), .y_out(y_out), .hit(hit), .busy(busy),
    .hit_count(hit_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!map_req && n < 40);
    if (!map_req) chk({tag, "_req_timeout"}, {31'd0, map_req}, 32'd1);
  endtask

  // Tied-ack step: check the query cell, then the committed position one cycle later.
  task automatic step(input string tag, input logic [7:0] ex, ey, cx, cy);
    int n;
    wait_req(tag, n);
    chk({tag, "_mx"}, map_x, ex);
    chk({tag, "_my"}, map_y, ey);
    @(negedge clk);
    chk({tag, "_x"}, x_out, cx);
    chk({tag, "_y"}, y_out, cy);
    chk({tag, "_req0"}, {31'd0, map_req}, 32'd0);
  endtask

  // Ack held off for 3 cycles; query cell must stay stable throughout.
  task automatic step_slow(input string tag, input logic [7:0] ex, ey, cx, cy);
    int n;
    wait_req(tag, n);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_mx_hold"}, map_x, ex);
      chk({tag, "_my_hold"}, map_y, ey);
      chk({tag, "_req_hold"}, {31'd0, map_req}, 32'd1);
      @(negedge clk);
    end
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    chk({tag, "_x"}, x_out, cx);
    chk({tag, "_y"}, y_out, cy);
  endtask

  task automatic do_reset;
    reset = 1'b0;
    x_increment = 0; x_decrement = 0; y_increment = 0; y_decrement = 0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n, reqs, hits, dbl;
    logic prev_hit;
    tie_ack = 1'b1; man_ack = 1'b0; blk_en = 1'b0;
    x_threshold = 8'd0; y_threshold = 8'd0;
    do_reset();

    // Reset state
    chk("rst_x", x_out, 8'd5);
    chk("rst_y", y_out, 8'd5);
    chk("rst_req", {31'd0, map_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hit", {31'd0, hit}, 32'd0);
    chk("rst_hcnt", {16'd0, hit_count}, 32'd0);

    // +X, threshold 8: first query 3 cycles after release, then every 4 cycles
    reset = 1'b1; x_increment = 1'b1; x_threshold = 8'd8;
    wait_req("xinc1", n);
    chk("xinc1_lat", n, 32'd3);
    chk("xinc1_mx", map_x, 8'd6);
    chk("xinc1_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("xinc1_x", x_out, 8'd6);
    chk("xinc1_busy0", {31'd0, busy}, 32'd0);
    wait_req("xinc2", n);
    chk("xinc2_lat", n, 32'd3);
    chk("xinc2_mx", map_x, 8'd7);
    @(negedge clk);
    chk("xinc2_x", x_out, 8'd7);
    step("xinc3", 8'd8, 8'd5, 8'd8, 8'd5);

    // Wall at x=7: stuck at 6, hit pulses each attempt
    do_reset();
    reset = 1'b1; x_increment = 1'b1; x_threshold = 8'd8; blk_en = 1'b1;
    step("blk0", 8'd6, 8'd5, 8'd6, 8'd5);
    for (int k = 1; k <= 2; k++) begin
      wait_req("blk", n);
      chk("blk_mx", map_x, 8'd7);
      @(negedge clk);
      chk("blk_hit", {31'd0, hit}, 32'd1);
      chk("blk_x", x_out, 8'd6);
      chk("blk_hcnt", {16'd0, hit_count}, HC_EN * k);
      @(negedge clk);
      chk("blk_hit_pulse", {31'd0, hit}, 32'd0);
    end
    blk_en = 1'b0;

    // -X down to 0, then local rejects: no queries, hits, x stays 0
    do_reset();
    reset = 1'b1; x_decrement = 1'b1; x_threshold = 8'd8;
    step("xdec4", 8'd4, 8'd5, 8'd4, 8'd5);
    step("xdec3", 8'd3, 8'd5, 8'd3, 8'd5);
    step("xdec2", 8'd2, 8'd5, 8'd2, 8'd5);
    step("xdec1", 8'd1, 8'd5, 8'd1, 8'd5);
    step("xdec0", 8'd0, 8'd5, 8'd0, 8'd5);
    reqs = 0; hits = 0; dbl = 0; prev_hit = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      reqs += int'(map_req);
      hits += int'(hit);
      if (hit && prev_hit) dbl++;
      prev_hit = hit;
    end
    chk("xlo_reqs", reqs, 32'd0);
    chk("xlo_hits_seen", {31'd0, hits > 0}, 32'd1);
    chk("xlo_hit_double", dbl, 32'd0);
    chk("xlo_x", x_out, 8'd0);

    // +Y to Y_MAX=9, then local rejects
    do_reset();
    reset = 1'b1; y_increment = 1'b1; y_threshold = 8'd15;
    step("yinc6", 8'd5, 8'd6, 8'd5, 8'd6);
    step("yinc7", 8'd5, 8'd7, 8'd5, 8'd7);
    step("yinc8", 8'd5, 8'd8, 8'd5, 8'd8);
    step("yinc9", 8'd5, 8'd9, 8'd5, 8'd9);
    reqs = 0; hits = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      reqs += int'(map_req);
      hits += int'(hit);
    end
    chk("yhi_reqs", reqs, 32'd0);
    chk("yhi_hits_seen", {31'd0, hits > 0}, 32'd1);
    chk("yhi_y", y_out, 8'd9);

    // Both axes, threshold 15, slow ack: X,Y,X,Y alternation
    do_reset();
    tie_ack = 1'b0;
    reset = 1'b1; x_increment = 1'b1; y_increment = 1'b1;
    x_threshold = 8'd15; y_threshold = 8'd15;
    step_slow("rr_x1", 8'd6, 8'd5, 8'd6, 8'd5);
    step_slow("rr_y1", 8'd6, 8'd6, 8'd6, 8'd6);
    step_slow("rr_x2", 8'd7, 8'd6, 8'd7, 8'd6);
    step_slow("rr_y2", 8'd7, 8'd7, 8'd7, 8'd7);
    step_slow("rr_x3", 8'd8, 8'd7, 8'd8, 8'd7);

    // Reset during QUERY_Y with ack withheld, then a stray ack
    wait_req("abort", n);
    chk("abort_my", map_y, 8'd8);
    chk("abort_mx", map_x, 8'd8);
    do_reset();
    chk("abort_req", {31'd0, map_req}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_x", x_out, 8'd5);
    chk("abort_y", y_out, 8'd5);
    reset = 1'b1; man_ack = 1'b1;
    repeat (4) @(negedge clk);
    man_ack = 1'b0;
    chk("late_ack_req", {31'd0, map_req}, 32'd0);
    chk("late_ack_x", x_out, 8'd5);
    chk("late_ack_y", y_out, 8'd5);
    chk("late_ack_hit", {31'd0, hit}, 32'd0);
    chk("late_ack_hcnt", {16'd0, hit_count}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
